// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data width, MIPS opcode constants, the zero
// register index and the decoded control bundle carried into execute.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle. The slave modport is
// the decode stage; the master modport is the surrounding pipeline.
interface id_stage_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs_val;
  logic [XLEN-1:0] ex_rt_val;
  logic [XLEN-1:0] ex_imm;
  logic [5:0]      ex_opcode;
  logic [5:0]      ex_funct;
  logic [4:0]      ex_dest;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm,
    input  ex_opcode, ex_funct, ex_dest, ex_reg_write, ex_mem_read,
    input  ex_mem_write, ex_branch, ex_jump, ex_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm,
    output ex_opcode, ex_funct, ex_dest, ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_branch, ex_jump, ex_illegal
  );

endinterface

// File: rtl/id_decoder.sv
// Combinational MIPS-style field decoder: control bundle, destination,
// source-used flags and the sign-extended 16-bit immediate.
module id_decoder
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic [31:0]             instr,
  output ctrl_t                   ctrl,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              dest,
  output logic                    use_rs,
  output logic                    use_rt,
  output logic signed [XLEN-1:0]  imm
);

  logic [5:0] opcode;
  logic [4:0] rd;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = {{(XLEN-16){instr[15]}}, instr[15:0]};

  always_comb begin
    ctrl   = '0;
    dest   = REG_ZERO;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest           = rd;
        ctrl.reg_write = (rd != REG_ZERO);
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      OP_ADDI: begin
        dest           = rt;
        ctrl.reg_write = 1'b1;
        use_rs         = 1'b1;
      end
      OP_LW: begin
        dest           = rt;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        use_rs         = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch    = 1'b1;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      OP_J: begin
        ctrl.jump      = 1'b1;
      end
      default: begin
        ctrl.illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode / operand-fetch stage with load-use hazard stall and ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data to operands.
module id_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  id_stage_if.slave        bus,
  output logic [4:0]       rf_read_reg_1,
  output logic [4:0]       rf_read_reg_2,
  input  logic [XLEN-1:0]  rf_read_data_1,
  input  logic [XLEN-1:0]  rf_read_data_2,
  input  logic             wb_write_enable,
  input  logic [4:0]       wb_write_reg,
  input  logic [XLEN-1:0]  wb_write_data,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic signed [XLEN-1:0] rs_val;
    logic signed [XLEN-1:0] rt_val;
    logic signed [XLEN-1:0] imm;
    logic [5:0]             opcode;
    logic [5:0]             funct;
    logic [4:0]             dest;
    ctrl_t                  ctrl;
  } idex_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Register 0 is hard-wired to zero whatever the register file returns.
  function automatic logic signed [XLEN-1:0] operand(input logic [4:0]      src,
                                                     input logic [XLEN-1:0] rf_data);
    logic signed [XLEN-1:0] v;
    v = rf_data;
`ifdef ID_WB_BYPASS_EN
    if (wb_write_enable && (wb_write_reg == src)) v = wb_write_data;
`endif
    if (src == REG_ZERO) v = '0;
    return v;
  endfunction

`ifndef ID_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_write_enable, wb_write_reg, wb_write_data};
`endif

  ctrl_t                  dec_ctrl;
  logic [4:0]             dec_rs;
  logic [4:0]             dec_rt;
  logic [4:0]             dec_dest;
  logic                   dec_use_rs;
  logic                   dec_use_rt;
  logic signed [XLEN-1:0] dec_imm;

  idex_t            idex_p0;
  idex_t            idex_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;
  logic             hazard;
  logic             xfer;

  id_decoder #(.XLEN(XLEN)) u_dec (
    .instr  (bus.in_instr),
    .ctrl   (dec_ctrl),
    .rs     (dec_rs),
    .rt     (dec_rt),
    .dest   (dec_dest),
    .use_rs (dec_use_rs),
    .use_rt (dec_use_rt),
    .imm    (dec_imm)
  );

  // ---- p0: decode and operand fetch ----
  assign rf_read_reg_1 = dec_rs;
  assign rf_read_reg_2 = dec_rt;

  always_comb begin
    idex_p0        = '0;
    idex_p0.pc     = bus.in_pc;
    idex_p0.rs_val = operand(dec_rs, rf_read_data_1);
    idex_p0.rt_val = operand(dec_rt, rf_read_data_2);
    idex_p0.imm    = dec_imm;
    idex_p0.opcode = bus.in_instr[31:26];
    idex_p0.funct  = bus.in_instr[5:0];
    idex_p0.dest   = dec_dest;
    idex_p0.ctrl   = dec_ctrl;
  end

  // A load still sitting in ID/EX cannot feed a consumer decoded this cycle.
  always_comb begin
    hazard = vld_p1 && idex_p1.ctrl.mem_read && (idex_p1.dest != REG_ZERO) &&
             ((dec_use_rs && (dec_rs == idex_p1.dest)) ||
              (dec_use_rt && (dec_rt == idex_p1.dest)));
  end

  assign bus.in_ready = flush || (!hazard && (!vld_p1 || bus.out_ready));
  assign xfer         = bus.in_valid && bus.in_ready && !flush;

  // ---- p1: ID/EX pipeline register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      idex_p1   <= '0;
      stall_cnt <= '0;
    end else begin
      if (bus.in_valid && hazard && !flush) stall_cnt <= sat_inc(stall_cnt);
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (xfer) begin
        vld_p1  <= 1'b1;
        idex_p1 <= idex_p0;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = vld_p1;
  assign bus.ex_pc        = idex_p1.pc;
  assign bus.ex_rs_val    = idex_p1.rs_val;
  assign bus.ex_rt_val    = idex_p1.rt_val;
  assign bus.ex_imm       = idex_p1.imm;
  assign bus.ex_opcode    = idex_p1.opcode;
  assign bus.ex_funct     = idex_p1.funct;
  assign bus.ex_dest      = idex_p1.dest;
  assign bus.ex_reg_write = idex_p1.ctrl.reg_write;
  assign bus.ex_mem_read  = idex_p1.ctrl.mem_read;
  assign bus.ex_mem_write = idex_p1.ctrl.mem_write;
  assign bus.ex_branch    = idex_p1.ctrl.branch;
  assign bus.ex_jump      = idex_p1.ctrl.jump;
  assign bus.ex_illegal   = idex_p1.ctrl.illegal;
  assign stall_cycles     = stall_cnt;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/operand-fetch stage of the 4-stage pipeline; sits directly upstream of the execute stage and drives the register-file read ports.
- Accepts fetched instructions with a valid/ready handshake and decodes MIPS-style fields.
- Fetches operands from the register file, detects load-use hazards and registers everything into the ID/EX pipeline register.

Parameters:
- XLEN, 32, data/PC width
- CNT_W, 16, width of saturating stall-cycle counter

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous squash of stage contents (branch/jump taken)
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of instruction
- rf_read_reg_1  out  5  = instr[25:21] (rs), combinational
- rf_read_reg_2  out  5  = instr[20:16] (rt), combinational
- rf_read_data_1  in  XLEN  register-file data for rs, same cycle
- rf_read_data_2  in  XLEN  register-file data for rt, same cycle
- wb_write_enable  in  1  writeback write strobe (same signal driving register file)
- wb_write_reg  in  5  writeback destination
- wb_write_data  in  XLEN  writeback data
- out_valid  out  1  ID/EX holds valid instruction
- out_ready  in  1  execute accepts
- ex_pc, ex_rs_val, ex_rt_val, ex_imm  out  XLEN  registered PC, operands, sign-extended imm[15:0]
- ex_opcode  out  6  / ex_funct  out  6  / ex_dest  out  5
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal  out  1 each
- stall_cycles  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset: all ID/EX outputs 0, out_valid=0, stall_cycles=0. Reset mid-transfer discards the in-flight instruction.
- Decode: opcode 0x00 R-type, dest=rd, writes unless rd=0. 0x08 addi, dest=rt. 0x23 lw, dest=rt, mem_read. 0x2B sw, mem_write, no dest. 0x04 beq, branch, no dest. 0x02 j, jump, uses no sources. Any other opcode: ex_illegal=1, reg_write/mem/branch/jump=0.
- Sources used: rs for R/addi/lw/sw/beq; rt for R/sw/beq.
- Hazard (combinational): out_valid && ex_mem_read && ex_dest!=0 && ex_dest matches a used source of in_instr.
- in_ready = !hazard && (!out_valid || out_ready). During flush, in_ready=1.
- Transfer when in_valid && in_ready: ID/EX loads on the next posedge, out_valid=1, latency 1 cycle.
- If no transfer and out_ready=1: out_valid<=0. A bubble follows a consumed load, and the dependent instruction is accepted the following cycle.
- flush has priority over everything except reset: out_valid<=0 and the presented instruction is dropped.
- While out_valid && !out_ready: all ex_* outputs hold stable.
- stall_cycles increments when in_valid && hazard && !flush, and saturates at all-ones.
- Register 0 source always yields 0, independent of the register-file data.

Optional Feature:
- ID_WB_BYPASS_EN
- Defined: for each source, if wb_write_enable && wb_write_reg==source && source!=0, the operand is wb_write_data instead of rf_read_data. This covers the register file's write-at-posedge timing.
- Undefined: operands come straight from rf_read_data_1/2. Same-cycle writeback then shows the old value.

Decomposition:
- Shared package pipe_pkg: XLEN, opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J), REG_ZERO, and a control-bundle struct (reg_write, mem_read, mem_write, branch, jump, illegal).
- One combinational sub-module, id_decoder: instruction word in; control bundle, dest, source-used flags and sign-extended imm out.

Test Plan:
- Reset asserted during a valid transfer -> out_valid=0, all ex_* = 0, stall_cycles=0 on the next cycle.
- addi $2,$1,-4 (0x2022FFFC) with rf_data_1=10 -> one cycle later out_valid=1, ex_rs_val=10, ex_imm=0xFFFFFFFC, ex_dest=2, ex_reg_write=1.
- lw $3,0($1) then add $4,$3,$5 -> in_ready=0 one cycle, a bubble (out_valid=0) follows the lw, add is accepted next, stall_cycles=1. A dependency on $0 gives no stall.
- out_ready=0 for 3 cycles with out_valid=1 -> ex_* unchanged, in_ready=0. Releasing out_ready accepts the waiting instruction.
- flush asserted while an instruction is held and a new one is presented -> next cycle out_valid=0, both instructions lost.
- With ID_WB_BYPASS_EN: wb writes $7=0xDEADBEEF while add reads $7 (rf gives 0) -> ex_rs_val=0xDEADBEEF. Without the macro -> 0. A wb write to $0 is never forwarded.
